// File: rtl/wheel_state_writeback.sv
// Writeback/sequencer for the wheel physics step: starts each step, captures streamed node and
// velocity beats into a shadow buffer and commits them atomically. Option: WHEEL_WB_VEL_CLAMP_EN.
module wheel_state_writeback #(
    parameter int NUM_NODES      = 8,
    parameter int POSITION_SIZE  = 16,
    parameter int VELOCITY_SIZE  = 16,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int VEL_LIMIT      = 2047
) (
    input  logic                                         clk_in,
    input  logic                                         rst_in,
    input  logic                                         init_in,
    input  logic [NUM_NODES-1:0][1:0][POSITION_SIZE-1:0] init_nodes,
    input  logic [NUM_NODES-1:0][1:0][VELOCITY_SIZE-1:0] init_velocities,
    input  logic                                         step_in,
    output logic                                         begin_out,
    input  logic [POSITION_SIZE-1:0]                     node_in_x,
    input  logic [POSITION_SIZE-1:0]                     node_in_y,
    input  logic                                         node_in_valid,
    input  logic                                         node_in_done,
    input  logic [VELOCITY_SIZE-1:0]                     vel_in_x,
    input  logic [VELOCITY_SIZE-1:0]                     vel_in_y,
    input  logic                                         vel_in_valid,
    input  logic                                         result_in,
    output logic [NUM_NODES-1:0][1:0][POSITION_SIZE-1:0] nodes_out,
    output logic [NUM_NODES-1:0][1:0][VELOCITY_SIZE-1:0] velocities_out,
    output logic                                         busy_out,
    output logic [15:0]                                  step_count_out,
    output logic [7:0]                                   missed_out,
    output logic                                         error_out
);

    localparam int CNT_W = $clog2(NUM_NODES) + 1;
    localparam int IDX_W = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_NODES);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

    if (NUM_NODES < 2 || TIMEOUT_CYCLES < 2 ||
        VEL_LIMIT < 1 || VEL_LIMIT >= (1 << (VELOCITY_SIZE - 1))) begin : g_bad_params
        $error("wheel_state_writeback: parameter out of range");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_COMMIT
    } state_t;

    state_t                                       state;
    logic [NUM_NODES-1:0][1:0][POSITION_SIZE-1:0] shadow_pos;
    logic [NUM_NODES-1:0][1:0][VELOCITY_SIZE-1:0] shadow_vel;
    logic [CNT_W-1:0]                             node_cnt;
    logic [CNT_W-1:0]                             vel_cnt;
    logic [WD_W-1:0]                              wd_cnt;

    logic                     node_full;
    logic                     vel_full;
    logic [CNT_W-1:0]         node_cnt_sum;
    logic [CNT_W-1:0]         vel_cnt_sum;
    logic                     node_complete;
    logic                     vel_complete;
    logic                     miss_inc;
    logic [IDX_W-1:0]         node_idx;
    logic [IDX_W-1:0]         vel_idx;
    logic [VELOCITY_SIZE-1:0] vel_wr_x;
    logic [VELOCITY_SIZE-1:0] vel_wr_y;

`ifdef WHEEL_WB_VEL_CLAMP_EN
    localparam logic signed [VELOCITY_SIZE-1:0] VEL_MAX = VELOCITY_SIZE'(VEL_LIMIT);
    localparam logic signed [VELOCITY_SIZE-1:0] VEL_MIN = -VEL_MAX;

    function automatic logic [VELOCITY_SIZE-1:0] sat_vel(input logic signed [VELOCITY_SIZE-1:0] v);
        if (v > VEL_MAX) return VEL_MAX;
        if (v < VEL_MIN) return VEL_MIN;
        return v;
    endfunction

    assign vel_wr_x = sat_vel(vel_in_x);
    assign vel_wr_y = sat_vel(vel_in_y);
`else
    assign vel_wr_x = vel_in_x;
    assign vel_wr_y = vel_in_y;
`endif

    // A step completes with this cycle's beat included, so result_in may share a cycle with the last beat.
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        node_full     = (node_cnt == CNT_FULL);
        vel_full      = (vel_cnt == CNT_FULL);
        node_cnt_sum  = node_cnt + CNT_W'(node_in_valid);
        vel_cnt_sum   = vel_cnt + CNT_W'(vel_in_valid);
        node_complete = node_full || (node_cnt_sum == CNT_FULL);
        vel_complete  = vel_full || (vel_cnt_sum == CNT_FULL);
        node_idx      = node_cnt[IDX_W-1:0];
        vel_idx       = vel_cnt[IDX_W-1:0];
        miss_inc      = (state != ST_IDLE) && step_in && !init_in && (missed_out != 8'hFF);
    end

    // NOTE: sequential state uses <= only, so every read in this block sees pre-edge values.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state          <= ST_IDLE;
            nodes_out      <= '0;
            velocities_out <= '0;
            // NOTE: the shadow buffer is reset like the live arrays; it is small and register-based.
            shadow_pos     <= '0;
            shadow_vel     <= '0;
            node_cnt       <= '0;
            vel_cnt        <= '0;
            wd_cnt         <= '0;
            begin_out      <= 1'b0;
            busy_out       <= 1'b0;
            step_count_out <= '0;
            missed_out     <= '0;
            error_out      <= 1'b0;
        end else begin
            begin_out <= 1'b0;
            if (miss_inc) begin
                missed_out <= missed_out + 8'd1;
            end

            if (init_in) begin
                nodes_out      <= init_nodes;
                velocities_out <= init_velocities;
                shadow_pos     <= init_nodes;
                shadow_vel     <= init_velocities;
                error_out      <= 1'b0;
                state          <= ST_IDLE;
                busy_out       <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (step_in) begin
                            begin_out <= 1'b1;
                            busy_out  <= 1'b1;
                            node_cnt  <= '0;
                            vel_cnt   <= '0;
                            wd_cnt    <= '0;
                            state     <= ST_RUN;
                        end
                    end

                    ST_RUN: begin
                        if (node_in_valid) begin
                            if (node_full) begin
                                error_out <= 1'b1;
                            end else begin
                                shadow_pos[node_idx] <= {node_in_x, node_in_y};
                                node_cnt             <= node_cnt + CNT_W'(1);
                            end
                        end
                        if (vel_in_valid) begin
                            if (vel_full) begin
                                error_out <= 1'b1;
                            end else begin
                                shadow_vel[vel_idx] <= {vel_wr_x, vel_wr_y};
                                vel_cnt             <= vel_cnt + CNT_W'(1);
                            end
                        end
                        if (node_in_done && (node_cnt_sum != CNT_FULL)) begin
                            error_out <= 1'b1;
                        end

                        if (result_in) begin
                            if (node_complete && vel_complete) begin
                                state <= ST_COMMIT;
                            end else begin
                                error_out <= 1'b1;
                                busy_out  <= 1'b0;
                                state     <= ST_IDLE;
                            end
                        end else if (wd_cnt == WD_LAST) begin
                            error_out <= 1'b1;
                            busy_out  <= 1'b0;
                            state     <= ST_IDLE;
                        end else begin
                            wd_cnt <= wd_cnt + WD_W'(1);
                        end
                    end

                    ST_COMMIT: begin
                        nodes_out      <= shadow_pos;
                        velocities_out <= shadow_vel;
                        step_count_out <= step_count_out + 16'd1;
                        busy_out       <= 1'b0;
                        state          <= ST_IDLE;
                    end

                    default: begin
                        busy_out <= 1'b0;
                        state    <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wheel_state_writeback.sv
// Bench for wheel_state_writeback: transaction-level model with queues, per-cycle compare,
// plus literal expectations. Clamp expectations follow WHEEL_WB_VEL_CLAMP_EN.
module tb_wheel_state_writeback;

    localparam int N  = 8;
    localparam int P  = 16;
    localparam int V  = 16;
    localparam int TO = 4096;
    localparam int VL = 2047;

    typedef logic [N-1:0][1:0][P-1:0] pos_arr_t;
    typedef logic [N-1:0][1:0][V-1:0] vel_arr_t;

    logic           clk_in = 1'b0;
    logic           rst_in = 1'b0;
    logic           init_in, step_in, node_in_valid, node_in_done, vel_in_valid, result_in;
    pos_arr_t       init_nodes;
    vel_arr_t       init_velocities;
    logic [P-1:0]   node_in_x, node_in_y;
    logic [V-1:0]   vel_in_x, vel_in_y;
    logic           begin_out, busy_out, error_out;
    pos_arr_t       nodes_out;
    vel_arr_t       velocities_out;
    logic [15:0]    step_count_out;
    logic [7:0]     missed_out;

    wheel_state_writeback #(
        .NUM_NODES(N), .POSITION_SIZE(P), .VELOCITY_SIZE(V),
        .TIMEOUT_CYCLES(TO), .VEL_LIMIT(VL)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .init_in(init_in),
        .init_nodes(init_nodes), .init_velocities(init_velocities),
        .step_in(step_in), .begin_out(begin_out),
        .node_in_x(node_in_x), .node_in_y(node_in_y),
        .node_in_valid(node_in_valid), .node_in_done(node_in_done),
        .vel_in_x(vel_in_x), .vel_in_y(vel_in_y), .vel_in_valid(vel_in_valid),
        .result_in(result_in), .nodes_out(nodes_out), .velocities_out(velocities_out),
        .busy_out(busy_out), .step_count_out(step_count_out),
        .missed_out(missed_out), .error_out(error_out)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    pos_arr_t     exp_pos;
    vel_arr_t     exp_vel;
    logic         exp_busy, exp_begin, exp_err;
    logic [15:0]  exp_steps;
    logic [7:0]   exp_missed;
    logic [2*P-1:0] q_pos[$];
    logic [2*V-1:0] q_vel[$];
    int           run_cycles;
    bit           m_commit;
    bit           chk_en = 1'b0;

    function automatic logic [V-1:0] mclamp(input logic [V-1:0] v);
        int s;
        s = int'($signed(v));
`ifdef WHEEL_WB_VEL_CLAMP_EN
        if (s > VL) s = VL;
        if (s < -VL) s = -VL;
`endif
        return V'(s);
    endfunction

    task automatic model_reset();
        exp_pos = '0; exp_vel = '0; exp_busy = 1'b0; exp_begin = 1'b0; exp_err = 1'b0;
        exp_steps = '0; exp_missed = '0; q_pos.delete(); q_vel.delete();
        run_cycles = 0; m_commit = 1'b0;
    endtask

    // Applies the rules for one clock edge, using the inputs that were held across it.
    task automatic model_update();
        int pos_before;
        exp_begin = 1'b0;
        if (exp_busy && step_in && !init_in && exp_missed != 8'hFF) exp_missed++;
        if (init_in) begin
            exp_pos = init_nodes; exp_vel = init_velocities; exp_err = 1'b0;
            exp_busy = 1'b0; m_commit = 1'b0;
        end else if (m_commit) begin
            for (int i = 0; i < N; i++) begin
                exp_pos[i] = q_pos[i];
                exp_vel[i] = q_vel[i];
            end
            exp_steps++;
            exp_busy = 1'b0; m_commit = 1'b0;
        end else if (exp_busy) begin
            run_cycles++;
            pos_before = q_pos.size();
            if (node_in_valid) begin
                if (q_pos.size() < N) q_pos.push_back({node_in_x, node_in_y});
                else exp_err = 1'b1;
            end
            if (vel_in_valid) begin
                if (q_vel.size() < N) q_vel.push_back({mclamp(vel_in_x), mclamp(vel_in_y)});
                else exp_err = 1'b1;
            end
            if (node_in_done && (pos_before + int'(node_in_valid)) != N) exp_err = 1'b1;
            if (result_in) begin
                if (q_pos.size() == N && q_vel.size() == N) m_commit = 1'b1;
                else begin exp_err = 1'b1; exp_busy = 1'b0; end
            end else if (run_cycles == TO) begin
                exp_err = 1'b1; exp_busy = 1'b0;
            end
        end else if (step_in) begin
            exp_begin = 1'b1; exp_busy = 1'b1;
            q_pos.delete(); q_vel.delete(); run_cycles = 0;
        end
    endtask

    always @(negedge clk_in) begin
        if (chk_en) begin
            check("nodes_out", 256'(nodes_out), 256'(exp_pos));
            check("velocities_out", 256'(velocities_out), 256'(exp_vel));
            check("busy_out", 256'(busy_out), 256'(exp_busy));
            check("begin_out", 256'(begin_out), 256'(exp_begin));
            check("error_out", 256'(error_out), 256'(exp_err));
            check("step_count_out", 256'(step_count_out), 256'(exp_steps));
            check("missed_out", 256'(missed_out), 256'(exp_missed));
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk_in);
        #1;
        model_update();
    endtask

    task automatic beat(input bit dn, input int x, input int y,
                        input bit dv, input int vx, input int vy, input bit done);
        node_in_valid = dn; node_in_x = P'(x); node_in_y = P'(y); node_in_done = done;
        vel_in_valid = dv;  vel_in_x = V'(vx);  vel_in_y = V'(vy);
        tick();
        node_in_valid = 1'b0; vel_in_valid = 1'b0; node_in_done = 1'b0;
    endtask

    task automatic do_init();
        init_in = 1'b1; tick(); init_in = 1'b0;
    endtask

    task automatic do_step();
        step_in = 1'b1; tick(); step_in = 1'b0;
    endtask

    task automatic do_result();
        result_in = 1'b1; tick(); result_in = 1'b0;
    endtask

    initial begin
        init_in = 1'b0; step_in = 1'b0; node_in_valid = 1'b0; node_in_done = 1'b0;
        vel_in_valid = 1'b0; result_in = 1'b0; node_in_x = '0; node_in_y = '0;
        vel_in_x = '0; vel_in_y = '0; init_nodes = '0; init_velocities = '0;
        model_reset();

        // Reset state
        #12;
        check("rst_nodes", 256'(nodes_out), 256'(0));
        check("rst_busy", 256'(busy_out), 256'(0));
        check("rst_begin", 256'(begin_out), 256'(0));
        check("rst_steps", 256'(step_count_out), 256'(0));
        check("rst_missed", 256'(missed_out), 256'(0));
        check("rst_error", 256'(error_out), 256'(0));
        rst_in = 1'b1;
        chk_en = 1'b1;

        // Init with node i = (i*10, -i), zero velocities; then a step with only 7 node beats
        for (int i = 0; i < N; i++) begin
            init_nodes[i][1] = P'(i * 10);
            init_nodes[i][0] = P'(-i);
        end
        do_init();
        check("init_node5", 256'(nodes_out[5]), 256'(32'h0032_FFFB));
        do_step();
        check("step_begin_hi", 256'(begin_out), 256'(1));
        check("step_busy", 256'(busy_out), 256'(1));
        tick();
        check("step_begin_lo", 256'(begin_out), 256'(0));
        for (int i = 0; i < 7; i++) beat(1, i, i, 1, i, i, 0);
        beat(0, 0, 0, 1, 7, 7, 0);
        do_result();
        check("short_err", 256'(error_out), 256'(1));
        check("short_idle", 256'(busy_out), 256'(0));
        check("short_steps", 256'(step_count_out), 256'(0));
        check("short_keep5", 256'(nodes_out[5]), 256'(32'h0032_FFFB));

        // Full step with node_in_done on the last beat; step_in during COMMIT, then at t+2
        do_step();
        for (int i = 0; i < N; i++) beat(1, i * 7 + 1, -(i * 5), 1, i * 100, -(i * 100), i == N - 1);
        do_result();
        check("pre_commit_busy", 256'(busy_out), 256'(1));
        check("pre_commit_node3", 256'(nodes_out[3]), 256'(32'h001E_FFFD));
        step_in = 1'b1;
        tick();
        check("commit_steps", 256'(step_count_out), 256'(1));
        check("commit_missed", 256'(missed_out), 256'(1));
        check("commit_node3", 256'(nodes_out[3]), 256'(32'h0016_FFF1));
        check("commit_vel2", 256'(velocities_out[2]), 256'(32'h00C8_FF38));
        tick();
        step_in = 1'b0;
        check("t2_begin", 256'(begin_out), 256'(1));
        check("t2_busy", 256'(busy_out), 256'(1));

        // Three dropped step pulses, then saturation of missed_out
        repeat (3) begin
            step_in = 1'b1; tick(); step_in = 1'b0; tick();
        end
        check("missed_4", 256'(missed_out), 256'(4));
        step_in = 1'b1;
        repeat (300) tick();
        step_in = 1'b0;
        check("missed_sat", 256'(missed_out), 256'(255));
        for (int i = 0; i < N; i++) beat(1, i * 3, i * 3 + 1, 1, i, -i, 0);
        do_result();
        tick();
        check("commit2_steps", 256'(step_count_out), 256'(2));
        check("commit2_node7", 256'(nodes_out[7]), 256'(32'h0015_0016));

        // Overflow: a 9th node beat is dropped and flags an error, commit still happens
        do_init();
        check("init_clr_err", 256'(error_out), 256'(0));
        do_step();
        for (int i = 0; i < N; i++) beat(1, i + 1, i + 2, 1, 0, 0, 0);
        beat(1, 16'hDEAD, 16'hBEEF, 0, 0, 0, 0);
        do_result();
        tick();
        check("ovf_err", 256'(error_out), 256'(1));
        check("ovf_steps", 256'(step_count_out), 256'(3));
        check("ovf_node7", 256'(nodes_out[7]), 256'(32'h0008_0009));

        // init and step together: init wins, no step starts
        do_init();
        init_in = 1'b1; step_in = 1'b1; tick(); init_in = 1'b0; step_in = 1'b0;
        check("initstep_begin", 256'(begin_out), 256'(0));
        check("initstep_busy", 256'(busy_out), 256'(0));

        // Early node_in_done flags an error without blocking the commit
        do_step();
        for (int i = 0; i < N; i++) beat(1, i, i, 1, i, i, i == 4);
        do_result();
        tick();
        check("done_err", 256'(error_out), 256'(1));
        check("done_steps", 256'(step_count_out), 256'(4));

        // Watchdog: busy for exactly TIMEOUT_CYCLES cycles
        do_init();
        do_step();
        repeat (TO - 1) tick();
        check("wd_still_busy", 256'(busy_out), 256'(1));
        tick();
        check("wd_idle", 256'(busy_out), 256'(0));
        check("wd_err", 256'(error_out), 256'(1));
        do_init();
        check("wd_init_clr", 256'(error_out), 256'(0));

        // Beats and result in IDLE are ignored
        for (int i = 0; i < 3; i++) beat(1, 99, 99, 1, 99, 99, 1);
        do_result();
        check("idle_ign_steps", 256'(step_count_out), 256'(4));
        check("idle_ign_err", 256'(error_out), 256'(0));

        // Velocity clamp behaviour (saturated only when the option is built in)
        do_step();
        for (int i = 0; i < N; i++) beat(1, i, i, 1, (i % 2 == 0) ? 5000 : -5000, i * 700 - 2500, 0);
        do_result();
        tick();
        check("clamp_steps", 256'(step_count_out), 256'(5));
`ifdef WHEEL_WB_VEL_CLAMP_EN
        check("clamp_vel0", 256'(velocities_out[0]), 256'(32'h07FF_F801));
        check("clamp_vel1", 256'(velocities_out[1]), 256'(32'hF801_F8F8));
`else
        check("clamp_vel0", 256'(velocities_out[0]), 256'(32'h1388_F63C));
        check("clamp_vel1", 256'(velocities_out[1]), 256'(32'hEC78_F8F8));
`endif

        // Asynchronous reset mid-RUN while begin_out is high
        do_step();
        chk_en = 1'b0;
        rst_in = 1'b0;
        #1;
        check("arst_nodes", 256'(nodes_out), 256'(0));
        check("arst_vels", 256'(velocities_out), 256'(0));
        check("arst_begin", 256'(begin_out), 256'(0));
        check("arst_busy", 256'(busy_out), 256'(0));
        check("arst_steps", 256'(step_count_out), 256'(0));
        check("arst_missed", 256'(missed_out), 256'(0));
        check("arst_err", 256'(error_out), 256'(0));
        model_reset();
        #1;
        rst_in = 1'b1;
        chk_en = 1'b1;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
